// File: rtl/corelet_ctrl_if.sv
// corelet_ctrl_if: controller-side bus to the input SRAM, L0, corelet
// instruction port, OFIFO, psum SRAM and SFU controls.
interface corelet_ctrl_if #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int addr_w = 11
);
    logic                in_cen;
    logic [addr_w-1:0]   in_addr;
    logic [bw*row-1:0]   in_q;
    logic [bw*row-1:0]   data_to_l0;
    logic                l0_wr;
    logic                l0_rd;
    logic                l0_full;
    logic [1:0]          inst;
    logic                ofifo_rd;
    logic                ofifo_valid;
    logic                p_wen;
    logic [addr_w-1:0]   p_addr;
    logic                accumulate;
    logic                relu;

    modport master (
        output in_cen, in_addr, data_to_l0, l0_wr, l0_rd, inst,
               ofifo_rd, p_wen, p_addr, accumulate, relu,
        input  in_q, l0_full, ofifo_valid
    );

    modport slave (
        input  in_cen, in_addr, data_to_l0, l0_wr, l0_rd, inst,
               ofifo_rd, p_wen, p_addr, accumulate, relu,
        output in_q, l0_full, ofifo_valid
    );
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: tile sequencer. Fills L0 with weights, kernel-loads,
// fills activations, executes, then drains the OFIFO into psum SRAM.
// Define CTRL_PERF_CNT_EN to add the stall_cycles/tile_cycles counters.
module corelet_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int addr_w  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] x_base,
    input  logic [addr_w-1:0] num_x,
    input  logic [addr_w-1:0] p_base,
    input  logic              acc_en,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    corelet_ctrl_if.master    bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       tile_cycles
`endif
);
    localparam int DW = bw * row;
    localparam int CW = addr_w + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ROW_C   = CW'(row);
    localparam logic [CW-1:0] WL_LAST = CW'(row + col - 1);

    if (psum_bw < 1) begin : g_param_check
        $error("psum_bw must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WFILL, S_WLOAD, S_XFILL, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [addr_w-1:0] wb_q, wb_d, xb_q, xb_d, nx_q, nx_d, pb_q, pb_d;
    logic              acc_q, acc_d, relu_q, relu_d;
    logic [CW-1:0]     rcnt_q, rcnt_d, wcnt_q, wcnt_d, cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d, pw_pend_q, pw_pend_d;
    logic [DW-1:0]     skid_q, skid_d;
    logic              skid_vld_q, skid_vld_d;

    logic              in_cen, l0_wr, l0_rd, ofifo_rd, p_wen;
    logic [addr_w-1:0] in_addr, p_addr, fill_base;
    logic [DW-1:0]     data_to_l0;
    logic [1:0]        inst;
    logic [CW-1:0]     fill_total, nx_ext;
    logic              fill_st;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign nx_ext = {1'b0, nx_q};

    assign bus.in_cen     = in_cen;
    assign bus.in_addr    = in_addr;
    assign bus.data_to_l0 = data_to_l0;
    assign bus.l0_wr      = l0_wr;
    assign bus.l0_rd      = l0_rd;
    assign bus.inst       = inst;
    assign bus.ofifo_rd   = ofifo_rd;
    assign bus.p_wen      = p_wen;
    assign bus.p_addr     = p_addr;
    assign bus.accumulate = busy & acc_q;
    assign bus.relu       = busy & relu_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wb_q       <= '0;
            xb_q       <= '0;
            nx_q       <= '0;
            pb_q       <= '0;
            acc_q      <= 1'b0;
            relu_q     <= 1'b0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            pw_pend_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            xb_q       <= xb_d;
            nx_q       <= nx_d;
            pb_q       <= pb_d;
            acc_q      <= acc_d;
            relu_q     <= relu_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            pw_pend_q  <= pw_pend_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        xb_d       = xb_q;
        nx_d       = nx_q;
        pb_d       = pb_q;
        acc_d      = acc_q;
        relu_d     = relu_q;
        rcnt_d     = rcnt_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        rd_pend_d  = 1'b0;
        pw_pend_d  = 1'b0;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        in_cen     = 1'b1;
        in_addr    = '0;
        data_to_l0 = '0;
        l0_wr      = 1'b0;
        l0_rd      = 1'b0;
        inst       = 2'b00;
        ofifo_rd   = 1'b0;
        p_wen      = 1'b1;
        p_addr     = '0;
        fill_st    = (state_q == S_WFILL) || (state_q == S_XFILL);
        fill_total = (state_q == S_WFILL) ? ROW_C : nx_ext;
        fill_base  = (state_q == S_WFILL) ? wb_q : xb_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wb_d       = w_base;
                    xb_d       = x_base;
                    nx_d       = num_x;
                    pb_d       = p_base;
                    acc_d      = acc_en;
                    relu_d     = relu_en;
                    rcnt_d     = '0;
                    wcnt_d     = '0;
                    cnt_d      = '0;
                    skid_vld_d = 1'b0;
                    state_d    = S_WFILL;
                end
            end
            S_WFILL, S_XFILL: begin
                // Data returning from last cycle's read goes to L0, or parks in
                // the skid when L0 is full; a parked word drains before any new
                // read, so the skid and an in-flight read never coexist.
                if (rd_pend_q) begin
                    if (!bus.l0_full) begin
                        l0_wr      = 1'b1;
                        data_to_l0 = bus.in_q;
                    end else begin
                        skid_d     = bus.in_q;
                        skid_vld_d = 1'b1;
                    end
                end else if (skid_vld_q && !bus.l0_full) begin
                    l0_wr      = 1'b1;
                    data_to_l0 = skid_q;
                    skid_vld_d = 1'b0;
                end
                if (!bus.l0_full && !skid_vld_q && (rcnt_q < fill_total)) begin
                    in_cen    = 1'b0;
                    in_addr   = fill_base + rcnt_q[addr_w-1:0];
                    rcnt_d    = rcnt_q + ONE;
                    rd_pend_d = 1'b1;
                end
                if (l0_wr) begin
                    wcnt_d = wcnt_q + ONE;
                    if (wcnt_q == fill_total - ONE) begin
                        rcnt_d  = '0;
                        wcnt_d  = '0;
                        cnt_d   = '0;
                        state_d = (state_q == S_WFILL) ? S_WLOAD : S_EXEC;
                    end
                end
            end
            S_WLOAD: begin
                if (cnt_q < ROW_C) begin
                    l0_rd = 1'b1;
                    inst  = 2'b01;
                end
                cnt_d = cnt_q + ONE;
                if (cnt_q == WL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_XFILL;
                end
            end
            S_EXEC: begin
                l0_rd = 1'b1;
                inst  = 2'b10;
                cnt_d = cnt_q + ONE;
                if (cnt_q == nx_ext - ONE) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pw_pend_q) begin
                    p_wen  = 1'b0;
                    p_addr = pb_q + wcnt_q[addr_w-1:0];
                    wcnt_d = wcnt_q + ONE;
                end
                if (bus.ofifo_valid && (rcnt_q < nx_ext)) begin
                    ofifo_rd = 1'b1;
                    rcnt_d   = rcnt_q + ONE;
                end
                pw_pend_d = ofifo_rd;
                if (pw_pend_q && (wcnt_q == nx_ext - ONE)) begin
                    rcnt_d    = '0;
                    wcnt_d    = '0;
                    pw_pend_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_q, tile_q;
    logic        tile_start, fill_stall;

    assign tile_start   = (state_q == S_IDLE) && start;
    assign fill_stall   = fill_st && (bus.l0_full || skid_vld_q);
    assign stall_cycles = stall_q;
    assign tile_cycles  = tile_q;

    // Performance counters, cleared per tile and frozen once idle
    always_ff @(posedge clk) begin
        if (reset || tile_start) begin
            stall_q <= '0;
            tile_q  <= '0;
        end else begin
            if (fill_stall) stall_q <= stall_q + 32'd1;
            if (busy)       tile_q  <= tile_q + 32'd1;
        end
    end
`else
    logic unused_fill_st;
    assign unused_fill_st = fill_st;
`endif
endmodule
